// File: rtl/sysbus_arbiter_if.sv
// One Sysbus-style port: request/address/data toward the bus, response beats back.
// "master" is the side that issues requests, "slave" is the side that answers them.
interface sysbus_arbiter_if #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13
);
   logic                      reqcyc;
   logic [BUS_DATA_WIDTH-1:0] req;
   logic [BUS_TAG_WIDTH-1:0]  reqtag;
   logic                      reqack;
   logic                      respcyc;
   logic [BUS_DATA_WIDTH-1:0] resp;
   logic [BUS_TAG_WIDTH-1:0]  resptag;
   logic                      respack;

   modport master (
      output reqcyc, req, reqtag, respack,
      input  reqack, respcyc, resp, resptag
   );

   modport slave (
      input  reqcyc, req, reqtag, respack,
      output reqack, respcyc, resp, resptag
   );
endinterface

// File: rtl/sysbus_arbiter.sv
// Two-requester Sysbus arbiter (port 0 = fetch, port 1 = data); grants whole bursts.
// Define SYSBUS_ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority (port 1 wins).
module sysbus_arbiter #(
   parameter int BUS_DATA_WIDTH = 64,
   parameter int BUS_TAG_WIDTH  = 13,
   parameter int BURST_BEATS    = 8
) (
   input  logic               clk,
   input  logic               reset,
   sysbus_arbiter_if.slave    m0,
   sysbus_arbiter_if.slave    m1,
   sysbus_arbiter_if.master   bus
);
   localparam int CNT_W = $clog2(BURST_BEATS) + 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ADDR    = 2'd1,
      WR_DATA = 2'd2,
      RD_RESP = 2'd3
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic                      r_owner;
   logic                      w_owner_nxt;
   logic [CNT_W-1:0]          r_beat_cnt;
   logic [CNT_W-1:0]          w_beat_cnt_nxt;
   logic                      w_done;
   logic                      w_winner;

   logic                      w_own_reqcyc;
   logic [BUS_DATA_WIDTH-1:0] w_own_req;
   logic [BUS_TAG_WIDTH-1:0]  w_own_reqtag;
   logic                      w_own_respack;

   logic                      w_fwd_reqack;
   logic                      w_fwd_respcyc;
   logic [BUS_DATA_WIDTH-1:0] w_fwd_resp;
   logic [BUS_TAG_WIDTH-1:0]  w_fwd_resptag;

   assign w_own_reqcyc  = r_owner ? m1.reqcyc  : m0.reqcyc;
   assign w_own_req     = r_owner ? m1.req     : m0.req;
   assign w_own_reqtag  = r_owner ? m1.reqtag  : m0.reqtag;
   assign w_own_respack = r_owner ? m1.respack : m0.respack;

`ifdef SYSBUS_ARB_ROUND_ROBIN_EN
   logic r_rr_ptr;

   // On a tie the pointer picks the port; a lone requester is always granted.
   always_comb begin
      if (m0.reqcyc && m1.reqcyc) begin
         w_winner = r_rr_ptr;
      end else begin
         w_winner = m1.reqcyc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rr_ptr <= 1'b0;
      end else if (w_done) begin
         r_rr_ptr <= ~r_owner;
      end
   end
`else
   assign w_winner = m1.reqcyc;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_owner    <= 1'b0;
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_beat_cnt <= w_beat_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_owner_nxt    = r_owner;
      w_beat_cnt_nxt = r_beat_cnt;
      w_done         = 1'b0;
      bus.reqcyc     = 1'b0;
      bus.req        = '0;
      bus.reqtag     = '0;
      bus.respack    = 1'b0;
      w_fwd_reqack   = 1'b0;
      w_fwd_respcyc  = 1'b0;
      w_fwd_resp     = '0;
      w_fwd_resptag  = '0;

      case (r_state)
         IDLE: begin
            if (m0.reqcyc || m1.reqcyc) begin
               w_owner_nxt = w_winner;
               w_state_nxt = ADDR;
            end
         end

         ADDR: begin
            bus.reqcyc   = w_own_reqcyc;
            bus.req      = w_own_req;
            bus.reqtag   = w_own_reqtag;
            w_fwd_reqack = bus.reqack;
            if (!w_own_reqcyc) begin
               w_state_nxt = IDLE;
            end else if (bus.reqack) begin
               w_beat_cnt_nxt = '0;
               w_state_nxt    = w_own_reqtag[BUS_TAG_WIDTH-1] ? RD_RESP : WR_DATA;
            end
         end

         WR_DATA: begin
            bus.reqcyc   = w_own_reqcyc;
            bus.req      = w_own_req;
            bus.reqtag   = w_own_reqtag;
            w_fwd_reqack = bus.reqack;
            if (w_own_reqcyc && bus.reqack) begin
               w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
               if (r_beat_cnt == LAST_BEAT) begin
                  w_state_nxt = IDLE;
                  w_done      = 1'b1;
               end
            end
         end

         RD_RESP: begin
            w_fwd_respcyc = bus.respcyc;
            w_fwd_resp    = bus.resp;
            w_fwd_resptag = bus.resptag;
            bus.respack   = w_own_respack & bus.respcyc;
            if (bus.respcyc && w_own_respack) begin
               w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
               if (r_beat_cnt == LAST_BEAT) begin
                  w_state_nxt = IDLE;
                  w_done      = 1'b1;
               end
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // The non-owner sees nothing from the bus.
   assign m0.reqack  = w_fwd_reqack  & ~r_owner;
   assign m1.reqack  = w_fwd_reqack  &  r_owner;
   assign m0.respcyc = w_fwd_respcyc & ~r_owner;
   assign m1.respcyc = w_fwd_respcyc &  r_owner;
   assign m0.resp    = r_owner ? '0 : w_fwd_resp;
   assign m1.resp    = r_owner ? w_fwd_resp : '0;
   assign m0.resptag = r_owner ? '0 : w_fwd_resptag;
   assign m1.resptag = r_owner ? w_fwd_resptag : '0;
endmodule

// File: tb/tb_sysbus_arbiter.sv
// Directed bench for sysbus_arbiter: reads, writes with stalls, ties, backpressure, reset, strays.
module tb_sysbus_arbiter;
   localparam int DW = 64;
   localparam int TW = 13;
   localparam int BB = 8;

   localparam logic [63:0] ST_IDLE = 64'd0;
   localparam logic [63:0] ST_ADDR = 64'd1;
   localparam logic [63:0] ST_WR   = 64'd2;
   localparam logic [63:0] ST_RD   = 64'd3;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   sysbus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) if_m0 ();
   sysbus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) if_m1 ();
   sysbus_arbiter_if #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW)) if_bus ();

   sysbus_arbiter #(
      .BUS_DATA_WIDTH(DW),
      .BUS_TAG_WIDTH (TW),
      .BURST_BEATS   (BB)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .m0   (if_m0),
      .m1   (if_m1),
      .bus  (if_bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_bus_reqcyc"},  64'(if_bus.reqcyc),  64'd0);
      check({tag, "_bus_req"},     64'(if_bus.req),     64'd0);
      check({tag, "_bus_reqtag"},  64'(if_bus.reqtag),  64'd0);
      check({tag, "_bus_respack"}, 64'(if_bus.respack), 64'd0);
      check({tag, "_m0_reqack"},   64'(if_m0.reqack),   64'd0);
      check({tag, "_m1_reqack"},   64'(if_m1.reqack),   64'd0);
      check({tag, "_m0_respcyc"},  64'(if_m0.respcyc),  64'd0);
      check({tag, "_m1_respcyc"},  64'(if_m1.respcyc),  64'd0);
      check({tag, "_m0_resp"},     64'(if_m0.resp),     64'd0);
      check({tag, "_m0_resptag"},  64'(if_m0.resptag),  64'd0);
   endtask

   initial begin
      reset          = 1'b1;
      if_m0.reqcyc   = 1'b0; if_m0.req = '0; if_m0.reqtag = '0; if_m0.respack = 1'b0;
      if_m1.reqcyc   = 1'b0; if_m1.req = '0; if_m1.reqtag = '0; if_m1.respack = 1'b0;
      if_bus.reqack  = 1'b0; if_bus.respcyc = 1'b0; if_bus.resp = '0; if_bus.resptag = '0;

      // Reset held with live inputs: outputs must stay quiet.
      cyc();
      cyc();
      if_m0.reqcyc   = 1'b1;
      if_bus.reqack  = 1'b1;
      if_bus.respcyc = 1'b1;
      if_bus.resp    = 64'hFFFF;
      #1;
      check_all_zero("rst");
      check("rst_state", 64'(dut.r_state), ST_IDLE);
      check("rst_cnt", 64'(dut.r_beat_cnt), 64'd0);
      if_m0.reqcyc   = 1'b0;
      if_bus.reqack  = 1'b0;
      if_bus.respcyc = 1'b0;
      if_bus.resp    = '0;
      cyc();
      reset = 1'b0;

      // Read by m0 from 0x1000, ack after two cycles, 8 beats with a stall on beat 3.
      cyc();
      if_m0.reqcyc = 1'b1;
      if_m0.req    = 64'h1000;
      if_m0.reqtag = 13'h1005;
      #1;
      check("rd_latency", 64'(if_bus.reqcyc), 64'd0);
      cyc();
      check("rd_state_addr", 64'(dut.r_state), ST_ADDR);
      check("rd_bus_reqcyc", 64'(if_bus.reqcyc), 64'd1);
      check("rd_bus_req", 64'(if_bus.req), 64'h1000);
      check("rd_bus_reqtag", 64'(if_bus.reqtag), 64'h1005);
      check("rd_m0_reqack_wait", 64'(if_m0.reqack), 64'd0);
      cyc();
      check("rd_state_addr2", 64'(dut.r_state), ST_ADDR);
      cyc();
      if_bus.reqack = 1'b1;
      #1;
      check("rd_m0_reqack", 64'(if_m0.reqack), 64'd1);
      check("rd_m1_reqack", 64'(if_m1.reqack), 64'd0);
      cyc();
      if_m0.reqcyc  = 1'b0;
      if_bus.reqack = 1'b0;
      if_m0.respack = 1'b1;
      check("rd_state_resp", 64'(dut.r_state), ST_RD);
      for (int i = 0; i < BB; i++) begin
         if (i == 3) begin
            repeat (2) begin
               if_m0.respack  = 1'b0;
               if_bus.respcyc = 1'b1;
               if_bus.resp    = 64'hA3;
               if_bus.resptag = 13'h1005;
               #1;
               check("bp_bus_respack", 64'(if_bus.respack), 64'd0);
               check("bp_m0_respcyc", 64'(if_m0.respcyc), 64'd1);
               check("bp_cnt", 64'(dut.r_beat_cnt), 64'd3);
               cyc();
            end
            if_m0.respack = 1'b1;
         end
         if_bus.respcyc = 1'b1;
         if_bus.resp    = 64'hA0 + 64'(i);
         if_bus.resptag = 13'h1005;
         #1;
         check("rd_cnt", 64'(dut.r_beat_cnt), 64'(i));
         check("rd_m0_respcyc", 64'(if_m0.respcyc), 64'd1);
         check("rd_m0_resp", 64'(if_m0.resp), 64'hA0 + 64'(i));
         check("rd_m0_resptag", 64'(if_m0.resptag), 64'h1005);
         check("rd_m1_respcyc", 64'(if_m1.respcyc), 64'd0);
         check("rd_m1_resp", 64'(if_m1.resp), 64'd0);
         check("rd_bus_respack", 64'(if_bus.respack), 64'd1);
         cyc();
      end
      if_bus.respcyc = 1'b0;
      if_m0.respack  = 1'b0;
      #1;
      check("rd_done_idle", 64'(dut.r_state), ST_IDLE);
      check("rd_done_respcyc", 64'(if_m0.respcyc), 64'd0);

      // Tie: m0 read and m1 write together; m1 goes first in both builds.
      if_m0.reqcyc = 1'b1;
      if_m0.req    = 64'h1000;
      if_m0.reqtag = 13'h1005;
      if_m1.reqcyc = 1'b1;
      if_m1.req    = 64'h2000;
      if_m1.reqtag = 13'h0009;
      #1;
      check("tie_idle_reqcyc", 64'(if_bus.reqcyc), 64'd0);
      cyc();
      check("tie_state", 64'(dut.r_state), ST_ADDR);
      check("tie_bus_req", 64'(if_bus.req), 64'h2000);
      check("tie_bus_reqtag", 64'(if_bus.reqtag), 64'h0009);
      if_bus.reqack = 1'b1;
      #1;
      check("tie_m1_reqack", 64'(if_m1.reqack), 64'd1);
      check("tie_m0_reqack", 64'(if_m0.reqack), 64'd0);
      cyc();
      check("wr_state", 64'(dut.r_state), ST_WR);
      for (int i = 0; i < BB; i++) begin
         if_m1.req = 64'hD0 + 64'(i);
         if (i == 4) begin
            if_bus.reqack = 1'b0;
            repeat (3) begin
               #1;
               check("wr_hold_req", 64'(if_bus.req), 64'hD4);
               check("wr_hold_state", 64'(dut.r_state), ST_WR);
               check("wr_hold_cnt", 64'(dut.r_beat_cnt), 64'd4);
               check("wr_hold_m1_reqack", 64'(if_m1.reqack), 64'd0);
               cyc();
            end
         end
         if_bus.reqack = 1'b1;
         #1;
         check("wr_bus_req", 64'(if_bus.req), 64'hD0 + 64'(i));
         check("wr_bus_reqcyc", 64'(if_bus.reqcyc), 64'd1);
         check("wr_m1_reqack", 64'(if_m1.reqack), 64'd1);
         check("wr_state_in", 64'(dut.r_state), ST_WR);
         cyc();
      end
      if_bus.reqack = 1'b0;
      if_m1.reqcyc  = 1'b0;
      if_m1.req     = '0;
      #1;
      check("wr_done_idle", 64'(dut.r_state), ST_IDLE);
      check("wr_bubble_reqcyc", 64'(if_bus.reqcyc), 64'd0);
      check("wr_bubble_m0_reqack", 64'(if_m0.reqack), 64'd0);

      // m0 still waiting: granted after the bubble, then reset lands on beat 5.
      cyc();
      check("m0_grant_state", 64'(dut.r_state), ST_ADDR);
      check("m0_grant_req", 64'(if_bus.req), 64'h1000);
      if_bus.reqack = 1'b1;
      #1;
      check("m0_grant_reqack", 64'(if_m0.reqack), 64'd1);
      cyc();
      if_m0.reqcyc  = 1'b0;
      if_bus.reqack = 1'b0;
      if_m0.respack = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if_bus.respcyc = 1'b1;
         if_bus.resp    = 64'hB0 + 64'(i);
         if_bus.resptag = 13'h1005;
         cyc();
      end
      if_bus.resp = 64'hB5;
      reset       = 1'b1;
      #1;
      check("pre_rst_cnt", 64'(dut.r_beat_cnt), 64'd5);
      cyc();
      check_all_zero("midrst");
      check("midrst_state", 64'(dut.r_state), ST_IDLE);
      check("midrst_cnt", 64'(dut.r_beat_cnt), 64'd0);
      check("midrst_owner", 64'(dut.r_owner), 64'd0);

      // Stray response in IDLE is ignored.
      reset          = 1'b0;
      if_m1.respack  = 1'b1;
      if_bus.resp    = 64'hBAD;
      #1;
      check("stray_m0_respcyc", 64'(if_m0.respcyc), 64'd0);
      check("stray_m1_respcyc", 64'(if_m1.respcyc), 64'd0);
      check("stray_bus_respack", 64'(if_bus.respack), 64'd0);
      check("stray_m0_resp", 64'(if_m0.resp), 64'd0);
      cyc();
      if_bus.respcyc = 1'b0;
      if_m0.respack  = 1'b0;
      if_m1.respack  = 1'b0;
      #1;
      check("stray_state", 64'(dut.r_state), ST_IDLE);

      // Fresh m1 request after reset, then abandoned before ack.
      if_m1.reqcyc = 1'b1;
      if_m1.req    = 64'h3000;
      if_m1.reqtag = 13'h1003;
      #1;
      check("post_rst_latency", 64'(if_bus.reqcyc), 64'd0);
      cyc();
      check("post_rst_state", 64'(dut.r_state), ST_ADDR);
      check("post_rst_req", 64'(if_bus.req), 64'h3000);
      check("post_rst_reqtag", 64'(if_bus.reqtag), 64'h1003);
      check("post_rst_owner", 64'(dut.r_owner), 64'd1);
      if_m1.reqcyc = 1'b0;
      #1;
      check("abandon_reqcyc", 64'(if_bus.reqcyc), 64'd0);
      cyc();
      check("abandon_state", 64'(dut.r_state), ST_IDLE);

      // Second tie: pointer is back at port 0 after reset in the round-robin build.
      if_m0.reqcyc = 1'b1;
      if_m0.req    = 64'h1000;
      if_m1.reqcyc = 1'b1;
      if_m1.req    = 64'h3000;
      cyc();
`ifdef SYSBUS_ARB_ROUND_ROBIN_EN
      check("tie2_bus_req", 64'(if_bus.req), 64'h1000);
      check("tie2_owner", 64'(dut.r_owner), 64'd0);
`else
      check("tie2_bus_req", 64'(if_bus.req), 64'h3000);
      check("tie2_owner", 64'(dut.r_owner), 64'd1);
`endif
      if_m0.reqcyc = 1'b0;
      if_m1.reqcyc = 1'b0;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
